// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: data width and the
// transmit-FIFO controller state encoding.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    TXF_IDLE  = 2'd0,
    TXF_ISSUE = 2'd1,
    TXF_WAIT  = 2'd2
  } txf_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with registered occupancy flags and a one-cycle
// overflow pulse when a push arrives while full.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_nxt;
  logic              push_ok;
  logic              pop_ok;

  // Gated by the registered flags, so a push while full is dropped even
  // if a pop frees a slot in the same cycle.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (push_ok && !pop_ok) begin
      level_nxt = level + LVL_ONE;
    end else if (!push_ok && pop_ok) begin
      level_nxt = level - LVL_ONE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      level    <= level_nxt;
      full     <= (level_nxt == LVL_FULL);
      empty    <= (level_nxt == '0);
      overflow <= push && full;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer in front of basic_uart: queues system-side bytes and
// issues them one per UART frame via tx_dat/tx_wr_ev.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_dat,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              tx_ready,
  input  logic              tx_done_ev,
  output logic [DATA_W-1:0] tx_dat,
  output logic              tx_wr_ev,
  output logic              busy
);

  txf_state_t        state;
  logic              pop;
  logic [DATA_W-1:0] fifo_dout;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .push     (wr_en),
    .pop      (pop),
    .din      (wr_dat),
    .dout     (fifo_dout),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  // Handshake with the UART: a byte is handed over only when we are IDLE,
  // the FIFO is non-empty and tx_ready=1; tx_wr_ev then strobes for one
  // cycle, and we hold off until tx_done_ev marks the end of that frame.
  assign pop = (state == TXF_IDLE) && !empty && tx_ready;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= TXF_IDLE;
      tx_dat   <= '0;
      tx_wr_ev <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tx_wr_ev <= 1'b0;
      case (state)
        TXF_IDLE: begin
          if (pop) begin
            tx_dat   <= fifo_dout;
            tx_wr_ev <= 1'b1;
            busy     <= 1'b1;
            state    <= TXF_ISSUE;
          end
        end
        TXF_ISSUE: begin
          state <= TXF_WAIT;
        end
        TXF_WAIT: begin
          if (tx_done_ev) begin
            busy  <= 1'b0;
            state <= TXF_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= TXF_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple UART frame model that
// answers tx_wr_ev with a tx_done_ev after frame_len cycles.
module tb_uart_tx_fifo;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_dat = 8'h00;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       tx_ready;
  logic       tx_done_ev = 1'b0;
  logic [7:0] tx_dat;
  logic       tx_wr_ev;
  logic       busy;

  logic       hold = 1'b0;
  int         cnt = 0;
  int         frame_len = 5;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_dat = 8'h00;
  logic       done_since = 1'b1;
  int         order_err = 0;
  int         stab_err = 0;
  int         ov_count = 0;
  int         tests_run = 0;
  int         tests_failed = 0;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_dat     (wr_dat),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .tx_ready   (tx_ready),
    .tx_done_ev (tx_done_ev),
    .tx_dat     (tx_dat),
    .tx_wr_ev   (tx_wr_ev),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  assign tx_ready = !hold && (cnt == 0);

  // UART model plus monitor: captures issued bytes, checks issue order
  // against frame completion and tx_dat stability at frame end.
  always @(negedge sys_clk) begin
    tx_done_ev = 1'b0;
    if (rst) begin
      cnt = 0;
      done_since = 1'b1;
    end else begin
      if (tx_wr_ev) begin
        got_q.push_back(tx_dat);
        if (!done_since) order_err++;
        done_since = 1'b0;
        last_dat = tx_dat;
        cnt = frame_len;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          tx_done_ev = 1'b1;
          done_since = 1'b1;
          if (tx_dat !== last_dat) stab_err++;
        end
      end
      if (overflow) ov_count++;
    end
  end

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1;
    wr_dat = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_events(input int target, input int budget, output bit ok,
                             output logic [4:0] pk);
    ok = 1'b0;
    pk = level;
    for (int i = 0; i < budget; i++) begin
      if (level > pk) pk = level;
      if (got_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({full, empty, level, overflow, tx_dat, tx_wr_ev, busy} !== {1'b0, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_values: full=%b empty=%b level=%0d ovf=%b tx_dat=%h wr_ev=%b busy=%b expected 0 1 0 0 00 0 0",
               full, empty, level, overflow, tx_dat, tx_wr_ev, busy);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    bit ok;
    frame_len = 5;
    hold = 1'b0;
    push(8'hA5);
    tests_run++;
    if ({tx_wr_ev, empty, level} !== {1'b0, 1'b0, 5'd1}) begin
      tests_failed++;
      $display("FAIL single_n1: wr_ev=%b empty=%b level=%0d expected 0 0 1", tx_wr_ev, empty, level);
    end
    tick();
    tests_run++;
    if ({tx_wr_ev, tx_dat, busy, empty} !== {1'b1, 8'hA5, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL single_strobe: wr_ev=%b tx_dat=%h busy=%b empty=%b expected 1 a5 1 1", tx_wr_ev, tx_dat, busy, empty);
    end
    tick();
    tests_run++;
    if (tx_wr_ev !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_pulse_width: wr_ev=%b expected 0", tx_wr_ev);
    end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      #1;
      if (tx_done_ev) begin
        ok = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!ok || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_busy_at_done: done_seen=%b busy=%b expected 1 1", ok, busy);
    end
    tick();
    tests_run++;
    if ({busy, empty} !== {1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL single_after_done: busy=%b empty=%b expected 0 1", busy, empty);
    end
  endtask

  task automatic test_burst;
    bit ok;
    logic [4:0] pk, pk2;
    int base;
    base = got_q.size();
    frame_len = 20;
    pk = 5'd0;
    exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < 5; i++) begin
      push(exp_q[i]);
      if (level > pk) pk = level;
    end
    wait_events(base + 5, 400, ok, pk2);
    if (pk2 > pk) pk = pk2;
    repeat (30) tick();
    tests_run++;
    if (!ok || got_q.size() != base + 5) begin
      tests_failed++;
      $display("FAIL burst_count: got %0d events expected 5", got_q.size() - base);
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (got_q[base+i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL burst_byte%0d: got %h expected %h", i, got_q[base+i], exp_q[i]);
      end
    end
    tests_run++;
    if (pk !== 5'd4) begin
      tests_failed++;
      $display("FAIL burst_peak_level: got %0d expected 4", pk);
    end
    tests_run++;
    if (order_err != 0) begin
      tests_failed++;
      $display("FAIL burst_pacing: %0d issues before frame end, expected 0", order_err);
    end
  endtask

  task automatic test_overflow;
    bit ok;
    logic [4:0] pk;
    int base, ov0;
    base = got_q.size();
    ov0 = ov_count;
    frame_len = 4;
    hold = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    tests_run++;
    if ({full, level, overflow} !== {1'b1, 5'd16, 1'b0}) begin
      tests_failed++;
      $display("FAIL ovf_full: full=%b level=%0d ovf=%b expected 1 16 0", full, level, overflow);
    end
    push(8'h20);
    tests_run++;
    if ({overflow, full, level} !== {1'b1, 1'b1, 5'd16}) begin
      tests_failed++;
      $display("FAIL ovf_pulse: ovf=%b full=%b level=%0d expected 1 1 16", overflow, full, level);
    end
    tick();
    tests_run++;
    if (overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_pulse_width: ovf=%b expected 0", overflow);
    end
    hold = 1'b0;
    wait_events(base + 16, 400, ok, pk);
    repeat (20) tick();
    tests_run++;
    if (!ok || got_q.size() != base + 16 || ov_count - ov0 != 1) begin
      tests_failed++;
      $display("FAIL ovf_drain: events=%0d ovf_pulses=%0d expected 16 1", got_q.size() - base, ov_count - ov0);
    end
    for (int i = 0; i < 16; i++) begin
      tests_run++;
      if (got_q[base+i] !== 8'h10 + 8'(i)) begin
        tests_failed++;
        $display("FAIL ovf_byte%0d: got %h expected %h", i, got_q[base+i], 8'h10 + 8'(i));
      end
    end
  endtask

  task automatic test_wrap;
    bit ok;
    logic [4:0] pk;
    int base;
    frame_len = 3;
    hold = 1'b0;
    base = got_q.size();
    for (int i = 0; i < 12; i++) push(8'hB0 + 8'(i));
    wait_events(base + 12, 300, ok, pk);
    repeat (10) tick();
    base = got_q.size();
    for (int i = 0; i < 12; i++) push(8'hC0 + 8'(i));
    wait_events(base + 12, 300, ok, pk);
    repeat (10) tick();
    tests_run++;
    if (!ok || got_q.size() != base + 12 || empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_count: events=%0d empty=%b expected 12 1", got_q.size() - base, empty);
    end
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if (got_q[base+i] !== 8'hC0 + 8'(i)) begin
        tests_failed++;
        $display("FAIL wrap_byte%0d: got %h expected %h", i, got_q[base+i], 8'hC0 + 8'(i));
      end
    end
  endtask

  task automatic test_push_during_pop;
    bit ok;
    logic [4:0] pk;
    int base;
    frame_len = 3;
    base = got_q.size();
    hold = 1'b1;
    exp_q = {8'hD0, 8'hD1, 8'hD2, 8'hD3};
    for (int i = 0; i < 3; i++) push(exp_q[i]);
    tests_run++;
    if (level !== 5'd3) begin
      tests_failed++;
      $display("FAIL pdp_level_before: got %0d expected 3", level);
    end
    hold = 1'b0;
    push(8'hD3);
    tests_run++;
    if ({level, tx_wr_ev, tx_dat} !== {5'd3, 1'b1, 8'hD0}) begin
      tests_failed++;
      $display("FAIL pdp_level_after: level=%0d wr_ev=%b tx_dat=%h expected 3 1 d0", level, tx_wr_ev, tx_dat);
    end
    wait_events(base + 4, 200, ok, pk);
    repeat (10) tick();
    tests_run++;
    if (!ok || got_q.size() != base + 4) begin
      tests_failed++;
      $display("FAIL pdp_count: got %0d events expected 4", got_q.size() - base);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (got_q[base+i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL pdp_byte%0d: got %h expected %h", i, got_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    logic [4:0] pk;
    int base;
    frame_len = 30;
    base = got_q.size();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i));
    hold = 1'b0;
    wait_events(base + 1, 50, ok, pk);
    tick();
    tick();
    tests_run++;
    if (!ok || {busy, level} !== {1'b1, 5'd3}) begin
      tests_failed++;
      $display("FAIL rstmid_setup: issued=%b busy=%b level=%0d expected 1 1 3", ok, busy, level);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({full, empty, level, overflow, tx_dat, tx_wr_ev, busy} !== {1'b0, 1'b1, 5'd0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL rstmid_async: full=%b empty=%b level=%0d ovf=%b tx_dat=%h wr_ev=%b busy=%b expected 0 1 0 0 00 0 0",
               full, empty, level, overflow, tx_dat, tx_wr_ev, busy);
    end
    repeat (3) tick();
    rst = 1'b0;
    base = got_q.size();
    repeat (40) tick();
    tests_run++;
    if (got_q.size() != base || tx_wr_ev !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_quiet: got %0d events expected 0", got_q.size() - base);
    end
    frame_len = 3;
    push(8'hF5);
    wait_events(base + 1, 20, ok, pk);
    tests_run++;
    if (!ok || got_q[base] !== 8'hF5) begin
      tests_failed++;
      $display("FAIL rstmid_resume: got %h expected f5", got_q[base]);
    end
    repeat (10) tick();
    tests_run++;
    if (order_err != 0 || stab_err != 0) begin
      tests_failed++;
      $display("FAIL pacing_stability: order_err=%0d stab_err=%0d expected 0 0", order_err, stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_push_during_pop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
